// File: rtl/sample_cnt_pkg.sv
// rtl/sample_cnt_pkg.sv - shared types and constants for the sample block counter
package sample_cnt_pkg;

  // Block size of the single-channel predecessor; a sensible power-on value for software.
  localparam int DEFAULT_BLOCK_SIZE = 1000;

  // Per-channel completion status, also consumed by the readout controller.
  typedef struct packed {
    logic done;
    logic pending;
    logic overrun;
  } blk_status_t;

endpackage

// File: rtl/sample_block_counter_if.sv
// rtl/sample_block_counter_if.sv - front-end / readout signal bundle for the block counter
interface sample_block_counter_if #(
  parameter int NUM_CH   = 4,
  parameter int CNT_BITS = 10
);

  logic [CNT_BITS-1:0]        block_size;
  logic [NUM_CH-1:0]          cnt_up;
  logic [NUM_CH-1:0]          clear;
  logic [NUM_CH-1:0]          ack;
  logic [NUM_CH*CNT_BITS-1:0] count;
  logic [NUM_CH-1:0]          block_done;
  logic [NUM_CH-1:0]          pending;
  logic [NUM_CH-1:0]          overrun;
  logic                       any_pending;

  // Driver side: front ends and readout controller.
  modport master (
    output block_size, cnt_up, clear, ack,
    input  count, block_done, pending, overrun, any_pending
  );

  // Counter side.
  modport slave (
    input  block_size, cnt_up, clear, ack,
    output count, block_done, pending, overrun, any_pending
  );

endinterface

// File: rtl/chan_block_counter.sv
// rtl/chan_block_counter.sv - one channel: sample count, block compare, pending/overrun flags
module chan_block_counter
  import sample_cnt_pkg::*;
#(
  parameter int CNT_BITS = 10
) (
  input  logic                clk,
  input  logic                n_reset,
  input  logic [CNT_BITS-1:0] block_size_i,
  input  logic                cnt_up_i,
  input  logic                clear_i,
  input  logic                ack_i,
  output logic [CNT_BITS-1:0] count_o,
  output blk_status_t         status_o
);

  logic [CNT_BITS-1:0] count_q, count_d;
  logic                done_q, done_d;
  logic                pend_q, pend_d;
  logic                ovr_q, ovr_d;
  logic                complete;
  logic [CNT_BITS:0]   count_inc;

  // One bit wider than the count so the >= compare never wraps at max block size.
  assign count_inc = {1'b0, count_q} + {{CNT_BITS{1'b0}}, 1'b1};

  // A completion is a sample that reaches or passes the block size while counting is enabled.
  assign complete = !clear_i && (block_size_i != '0) && cnt_up_i &&
                    (count_inc >= {1'b0, block_size_i});

  // Next-state: clear beats counting; block_size==0 freezes the counter.
  always_comb begin
    count_d = count_q;
    done_d  = 1'b0;
    pend_d  = pend_q;
    ovr_d   = ovr_q;

    if (clear_i) begin
      count_d = '0;
    end else if (block_size_i == '0) begin
      count_d = count_q;
    end else if (complete) begin
      count_d = '0;
      done_d  = 1'b1;
    end else if (cnt_up_i) begin
      count_d = count_inc[CNT_BITS-1:0];
    end

    // A new block wins over a simultaneous ack.
    if (complete) begin
      pend_d = 1'b1;
    end else if (ack_i) begin
      pend_d = 1'b0;
    end

    if (clear_i) begin
      ovr_d = 1'b0;
    end else if (complete && pend_q && !ack_i) begin
      ovr_d = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      count_q <= '0;
      done_q  <= 1'b0;
      pend_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      done_q  <= done_d;
      pend_q  <= pend_d;
      ovr_q   <= ovr_d;
    end
  end

  assign count_o          = count_q;
  assign status_o.done    = done_q;
  assign status_o.pending = pend_q;
  assign status_o.overrun = ovr_q;

endmodule

// File: rtl/sample_block_counter.sv
// rtl/sample_block_counter.sv - multi-channel sample block counter top
module sample_block_counter
  import sample_cnt_pkg::*;
#(
  parameter int NUM_CH   = 4,
  parameter int CNT_BITS = 10
) (
  input  logic                   clk,
  input  logic                   n_reset,
  sample_block_counter_if.slave  bus
);

  logic [NUM_CH*CNT_BITS-1:0] count_w;
  logic [NUM_CH-1:0]          done_w;
  logic [NUM_CH-1:0]          pend_w;
  logic [NUM_CH-1:0]          ovr_w;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    blk_status_t status_w;

    chan_block_counter #(
      .CNT_BITS (CNT_BITS)
    ) u_chan (
      .clk          (clk),
      .n_reset      (n_reset),
      .block_size_i (bus.block_size),
      .cnt_up_i     (bus.cnt_up[i]),
      .clear_i      (bus.clear[i]),
      .ack_i        (bus.ack[i]),
      .count_o      (count_w[i*CNT_BITS +: CNT_BITS]),
      .status_o     (status_w)
    );

    assign done_w[i] = status_w.done;
    assign pend_w[i] = status_w.pending;
    assign ovr_w[i]  = status_w.overrun;
  end

  assign bus.count       = count_w;
  assign bus.block_done  = done_w;
  assign bus.pending     = pend_w;
  assign bus.overrun     = ovr_w;
  assign bus.any_pending = |pend_w;

endmodule
